// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: 2-flop synchroniser, counter debounce,
// registered edge pulses and an optional auto-repeat press strobe per channel.
module input_conditioner #(
    parameter int                  CHANNELS      = 4,
    parameter int                  STABLE_CYCLES = 1024,
    parameter int                  REPEAT_DELAY  = 500000,
    parameter int                  REPEAT_PERIOD = 125000,
    parameter logic [CHANNELS-1:0] REPEAT_MASK   = {CHANNELS{1'b0}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] any,
    output logic [CHANNELS-1:0] press
);

    localparam int DMAX = STABLE_CYCLES - 1;
    localparam int DW   = (DMAX < 1) ? 1 : $clog2(DMAX + 1);
    localparam int RMAX = ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) - 1;
    localparam int RW   = (RMAX < 1) ? 1 : $clog2(RMAX + 1);

    localparam logic [DW-1:0] DCNT_LAST   = DW'(DMAX);
    localparam logic [DW-1:0] DCNT_ONE    = DW'(32'd1);
    localparam logic [RW-1:0] RCNT_D_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RCNT_P_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] RCNT_ONE    = RW'(32'd1);

    typedef enum logic {
        PH_INITIAL   = 1'b0,
        PH_REPEATING = 1'b1
    } phase_t;

    logic [CHANNELS-1:0] sync1_r, sync2_r;
    logic [CHANNELS-1:0] level_r, rise_r, fall_r, any_r, press_r;
    logic [DW-1:0]       dcnt_r      [CHANNELS];
    logic [RW-1:0]       rcnt_r      [CHANNELS];
    phase_t              phase_r     [CHANNELS];

    logic [CHANNELS-1:0] level_next_s, rise_next_s, fall_next_s, press_next_s;
    logic [DW-1:0]       dcnt_next_s [CHANNELS];
    logic [RW-1:0]       rcnt_next_s [CHANNELS];
    phase_t              phase_next_s[CHANNELS];

    // Debounce, edge detection and repeat-strobe next-state logic per channel.
    always_comb begin
        level_next_s = level_r;
        rise_next_s  = {CHANNELS{1'b0}};
        fall_next_s  = {CHANNELS{1'b0}};
        press_next_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            dcnt_next_s[i]  = '0;
            rcnt_next_s[i]  = '0;
            phase_next_s[i] = PH_INITIAL;

            if (sync2_r[i] == level_r[i]) begin
                dcnt_next_s[i] = '0;
            end else if (dcnt_r[i] == DCNT_LAST) begin
                level_next_s[i] = sync2_r[i];
                dcnt_next_s[i]  = '0;
            end else begin
                dcnt_next_s[i] = dcnt_r[i] + DCNT_ONE;
            end

            rise_next_s[i] = level_next_s[i] & ~level_r[i];
            fall_next_s[i] = ~level_next_s[i] & level_r[i];

            // Repeat state only advances while the next level is held high.
            if (REPEAT_MASK[i] == 1'b0) begin
                press_next_s[i] = rise_next_s[i];
            end else if (level_next_s[i] == 1'b0) begin
                press_next_s[i] = 1'b0;
            end else if (rise_next_s[i]) begin
                press_next_s[i] = 1'b1;
            end else begin
                case (phase_r[i])
                    PH_INITIAL: begin
                        if (rcnt_r[i] == RCNT_D_LAST) begin
                            press_next_s[i] = 1'b1;
                            phase_next_s[i] = PH_REPEATING;
                        end else begin
                            rcnt_next_s[i]  = rcnt_r[i] + RCNT_ONE;
                            phase_next_s[i] = PH_INITIAL;
                        end
                    end
                    PH_REPEATING: begin
                        if (rcnt_r[i] == RCNT_P_LAST) begin
                            press_next_s[i] = 1'b1;
                        end else begin
                            rcnt_next_s[i] = rcnt_r[i] + RCNT_ONE;
                        end
                        phase_next_s[i] = PH_REPEATING;
                    end
                    default: begin
                        phase_next_s[i] = PH_INITIAL;
                    end
                endcase
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= {CHANNELS{1'b0}};
            sync2_r <= {CHANNELS{1'b0}};
            level_r <= {CHANNELS{1'b0}};
            rise_r  <= {CHANNELS{1'b0}};
            fall_r  <= {CHANNELS{1'b0}};
            any_r   <= {CHANNELS{1'b0}};
            press_r <= {CHANNELS{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                dcnt_r[i]  <= '0;
                rcnt_r[i]  <= '0;
                phase_r[i] <= PH_INITIAL;
            end
        end else begin
            sync1_r <= in;
            sync2_r <= sync1_r;
            level_r <= level_next_s;
            rise_r  <= rise_next_s;
            fall_r  <= fall_next_s;
            any_r   <= rise_next_s | fall_next_s;
            press_r <= press_next_s;
            for (int i = 0; i < CHANNELS; i++) begin
                dcnt_r[i]  <= dcnt_next_s[i];
                rcnt_r[i]  <= rcnt_next_s[i];
                phase_r[i] <= phase_next_s[i];
            end
        end
    end

    assign level = level_r;
    assign rise  = rise_r;
    assign fall  = fall_r;
    assign any   = any_r;
    assign press = press_r;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: cycle-by-cycle comparison against a window/time
// based model, plus hand-computed checks at the interesting cycles.
module tb_input_conditioner;

    localparam int         CH   = 2;
    localparam int         S    = 4;
    localparam int         D    = 10;
    localparam int         P    = 3;
    localparam logic [1:0] MASK = 2'b10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] in;
    logic [1:0] level, rise, fall, any, press;

    int n_vec = 0;
    int n_err = 0;

    input_conditioner #(
        .CHANNELS      (CH),
        .STABLE_CYCLES (S),
        .REPEAT_DELAY  (D),
        .REPEAT_PERIOD (P),
        .REPEAT_MASK   (MASK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .level (level),
        .rise  (rise),
        .fall  (fall),
        .any   (any),
        .press (press)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Model: synchroniser delay line, last-S-samples window for debounce,
    // and press times derived from elapsed cycles since the rise.
    logic [1:0]   m_s1, m_s2, m_level, m_rise, m_fall, m_press;
    logic [S-1:0] m_win [CH];
    int           t0    [CH];
    int           cyc;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                m_s1 = 2'b00; m_s2 = 2'b00; m_level = 2'b00;
                m_rise = 2'b00; m_fall = 2'b00; m_press = 2'b00;
                for (int c = 0; c < CH; c++) begin
                    m_win[c] = {S{1'b0}};
                    t0[c] = 0;
                end
                cyc = 0;
            end else begin
                cyc++;
                for (int c = 0; c < CH; c++) begin
                    logic s2pre, old, nw;
                    int   e;
                    s2pre   = m_s2[c];
                    m_s2[c] = m_s1[c];
                    m_s1[c] = in[c];
                    m_win[c] = {m_win[c][S-2:0], s2pre};
                    old = m_level[c];
                    nw  = (m_win[c] == (old ? {S{1'b0}} : {S{1'b1}})) ? ~old : old;
                    m_level[c] = nw;
                    m_rise[c]  = nw & ~old;
                    m_fall[c]  = ~nw & old;
                    if (nw && !old) begin
                        t0[c] = cyc;
                        m_press[c] = 1'b1;
                    end else if (nw && MASK[c]) begin
                        e = cyc - t0[c];
                        m_press[c] = (e == D) || ((e > D) && ((e - D) % P == 0));
                    end else begin
                        m_press[c] = 1'b0;
                    end
                end
            end
            chk("level", level, m_level);
            chk("rise",  rise,  m_rise);
            chk("fall",  fall,  m_fall);
            chk("any",   any,   m_rise | m_fall);
            chk("press", press, m_press);
        end
    end

    task automatic drive(input logic [1:0] v);
        @(negedge clk);
        in = v;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        in    = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_level", level, 2'b00);
        chk("reset_press", press, 2'b00);
        rst_n = 1'b1;

        // idle
        wait_edges(50);
        chk("idle_level", level, 2'b00);

        // ch0 press, level after edge 5, no repeat while held
        drive(2'b01);
        wait_edges(5);
        chk("ch0_lvl_e4", level, 2'b00);
        wait_edges(1);
        chk("ch0_lvl_e5",  level, 2'b01);
        chk("ch0_rise_e5", rise,  2'b01);
        chk("ch0_any_e5",  any,   2'b01);
        chk("ch0_prs_e5",  press, 2'b01);
        wait_edges(1);
        chk("ch0_rise_e6", rise, 2'b00);
        wait_edges(40);
        chk("ch0_hold_prs", press, 2'b00);
        drive(2'b00);
        wait_edges(6);
        chk("ch0_fall", fall, 2'b01);
        wait_edges(5);

        // 3-cycle glitch ignored, 4-cycle pulse accepted
        drive(2'b01);
        repeat (2) @(negedge clk);
        drive(2'b00);
        wait_edges(10);
        chk("glitch3_lvl", level, 2'b00);
        drive(2'b01);
        repeat (3) @(negedge clk);
        drive(2'b00);
        wait_edges(2);
        chk("pulse4_lvl",  level, 2'b01);
        chk("pulse4_rise", rise,  2'b01);
        wait_edges(10);

        // ch1 auto-repeat: t0, t0+10, t0+13, t0+16 ...
        drive(2'b10);
        wait_edges(6);
        chk("rep_t0_prs",  press, 2'b10);
        chk("rep_t0_rise", rise,  2'b10);
        wait_edges(9);
        chk("rep_t9_prs", press, 2'b00);
        wait_edges(1);
        chk("rep_t10_prs", press, 2'b10);
        chk("rep_t10_rise", rise, 2'b00);
        wait_edges(3);
        chk("rep_t13_prs", press, 2'b10);
        wait_edges(2);
        chk("rep_t15_prs", press, 2'b00);
        wait_edges(1);
        chk("rep_t16_prs", press, 2'b10);
        wait_edges(14);
        drive(2'b00);
        wait_edges(10);

        // ch1 level released at t0+12: no strobes after the fall
        drive(2'b10);
        repeat (12) @(negedge clk);
        in = 2'b00;
        wait_edges(6);
        chk("rel_fall",  fall,  2'b10);
        chk("rel_level", level, 2'b00);
        wait_edges(1);
        chk("rel_t13_prs", press, 2'b00);
        wait_edges(10);
        drive(2'b10);
        wait_edges(6);
        chk("repress_t0",  press, 2'b10);
        wait_edges(10);
        chk("repress_t10", press, 2'b10);
        wait_edges(1);

        // reset mid-repeat (ch1) and mid-debounce (ch0)
        drive(2'b11);
        wait_edges(2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_level", level, 2'b00);
        chk("arst_rise",  rise,  2'b00);
        chk("arst_fall",  fall,  2'b00);
        chk("arst_any",   any,   2'b00);
        chk("arst_press", press, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        wait_edges(5);
        chk("post_rst_e4", level, 2'b00);
        wait_edges(1);
        chk("post_rst_lvl",  level, 2'b11);
        chk("post_rst_rise", rise,  2'b11);
        chk("post_rst_prs",  press, 2'b11);
        wait_edges(10);
        chk("post_rst_rep", press, 2'b10);
        wait_edges(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
